// File: rtl/vga_frame_capture.sv
// vga_frame_capture: monitors the VGA pin stream on vga_clk, recovers frame and
// line boundaries, measures active width/height, computes a per-frame CRC-32
// (poly 0x04C11DB7, MSB-first, init/final-XOR 0xFFFFFFFF) over {r,g,b} active
// pixels and flags dimension and sync errors.
// Optional build macro VGA_CAP_LINE_CRC_EN adds per-line CRC outputs
// (line_done, line_crc, line_num).
module vga_frame_capture #(
  parameter int EXP_WIDTH     = 640,
  parameter int EXP_HEIGHT    = 480,
  parameter int HS_ACTIVE_LOW = 1,
  parameter int VS_ACTIVE_LOW = 1,
  parameter int CNT_W         = 12
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             capture_en,
  input  logic             err_clear,
  input  logic             vga_hs,
  input  logic             vga_vs,
  input  logic             vga_blank_n,
  input  logic [7:0]       vga_r,
  input  logic [7:0]       vga_g,
  input  logic [7:0]       vga_b,
`ifdef VGA_CAP_LINE_CRC_EN
  output logic             line_done,
  output logic [31:0]      line_crc,
  output logic [CNT_W-1:0] line_num,
`endif
  output logic             frame_done,
  output logic [31:0]      frame_crc,
  output logic [CNT_W-1:0] active_width,
  output logic [CNT_W-1:0] active_height,
  output logic [15:0]      frame_count,
  output logic             dim_error,
  output logic             sync_error,
  output logic             locked
);

  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic {SEARCH, FRAME} state_t;

  state_t state, state_nxt;

  logic             hs_a_p1, vs_a_p1, blank_p1, vs_a_p2, blank_p2;
  logic [23:0]      rgb_p1;
  logic             vs_start, line_end, pixel, rearm, frame_end;
  logic [CNT_W-1:0] x, y, width_ref;
  logic             line_mismatch, overflow;
  logic [CNT_W:0]   x_inc, y_inc;
  logic [31:0]      crc_acc, crc_upd;
  logic             end_pend_p2, snap_dim_p2;
  logic [31:0]      snap_crc_p2;
  logic [CNT_W-1:0] snap_w_p2, snap_h_p2;

  // One 24-bit word through the CRC-32 shift register, bit 23 first.
  function automatic logic [31:0] crc24_step(input logic [31:0] crc, input logic [23:0] word);
    logic [31:0] c;
    c = crc;
    for (int i = 23; i >= 0; i--) begin
      if (c[31] ^ word[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  // Saturating increment; MSB of the result flags that the counter was already full.
  function automatic logic [CNT_W:0] cnt_inc(input logic [CNT_W-1:0] c);
    if (&c) return {1'b1, c};
    else    return {1'b0, c + CNT_W'(1)};
  endfunction

  // Input stage 1 and 2: sync/blank control with polarity normalised to 1 = asserted.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hs_a_p1  <= 1'b0;
      vs_a_p1  <= 1'b0;
      blank_p1 <= 1'b0;
      vs_a_p2  <= 1'b0;
      blank_p2 <= 1'b0;
    end else begin
      hs_a_p1  <= (HS_ACTIVE_LOW != 0) ? ~vga_hs : vga_hs;
      vs_a_p1  <= (VS_ACTIVE_LOW != 0) ? ~vga_vs : vga_vs;
      blank_p1 <= vga_blank_n;
      vs_a_p2  <= vs_a_p1;
      blank_p2 <= blank_p1;
    end
  end

  // Input stage 1 pixel data; carries no control meaning, so it is not reset.
  always_ff @(posedge vga_clk) begin
    rgb_p1 <= {vga_r, vga_g, vga_b};
  end

  assign vs_start = vs_a_p1 & ~vs_a_p2;
  assign line_end = ~blank_p1 & blank_p2;
  assign pixel    = blank_p1;
  assign locked   = (state == FRAME);

  // Lock state register.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) state <= SEARCH;
    else       state <= state_nxt;
  end

  // Next state plus frame boundary strobes; a frame only ends while locked and enabled.
  always_comb begin
    state_nxt = state;
    rearm     = 1'b0;
    frame_end = 1'b0;
    if (!capture_en) begin
      state_nxt = SEARCH;
    end else if (vs_start) begin
      state_nxt = FRAME;
      rearm     = 1'b1;
      frame_end = (state == FRAME);
    end
  end

  // Counter increments and the CRC including the current pixel (if any).
  always_comb begin
    x_inc   = cnt_inc(x);
    y_inc   = cnt_inc(y);
    crc_upd = pixel ? crc24_step(crc_acc, rgb_p1) : crc_acc;
  end

  // Per-frame measurement: held clear in SEARCH and re-armed at every vs_start.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      x             <= '0;
      y             <= '0;
      width_ref     <= '0;
      line_mismatch <= 1'b0;
      overflow      <= 1'b0;
      crc_acc       <= CRC_INIT;
    end else if (state == SEARCH || rearm) begin
      x             <= '0;
      y             <= '0;
      width_ref     <= '0;
      line_mismatch <= 1'b0;
      overflow      <= 1'b0;
      crc_acc       <= CRC_INIT;
    end else if (pixel) begin
      x        <= x_inc[CNT_W-1:0];
      overflow <= overflow | x_inc[CNT_W];
      crc_acc  <= crc_upd;
    end else if (line_end) begin
      y        <= y_inc[CNT_W-1:0];
      overflow <= overflow | y_inc[CNT_W];
      if (y == '0)            width_ref     <= x;
      else if (x != width_ref) line_mismatch <= 1'b1;
      x <= '0;
    end
  end

  // Stage p2 strobe: a finished frame is waiting to be published.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) end_pend_p2 <= 1'b0;
    else       end_pend_p2 <= frame_end;
  end

  // Stage p2 snapshot of the finished frame; a pixel coincident with vs_start belongs to it.
  always_ff @(posedge vga_clk) begin
    if (frame_end) begin
      snap_crc_p2 <= crc_upd ^ CRC_INIT;
      snap_w_p2   <= width_ref;
      snap_h_p2   <= y;
      snap_dim_p2 <= (width_ref != CNT_W'(EXP_WIDTH)) | (y != CNT_W'(EXP_HEIGHT)) |
                     line_mismatch | overflow | (pixel & x_inc[CNT_W]);
    end
  end

  // Published last-frame results; they hold while unlocked.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_done    <= 1'b0;
      frame_crc     <= '0;
      active_width  <= '0;
      active_height <= '0;
      frame_count   <= '0;
      dim_error     <= 1'b0;
    end else begin
      frame_done <= end_pend_p2;
      if (end_pend_p2) begin
        frame_crc     <= snap_crc_p2;
        active_width  <= snap_w_p2;
        active_height <= snap_h_p2;
        frame_count   <= frame_count + 16'd1;
        dim_error     <= snap_dim_p2;
      end
    end
  end

  // Sticky sync error: active video during a sync pulse; a new set beats err_clear.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset)                                  sync_error <= 1'b0;
    else if (blank_p1 & (hs_a_p1 | vs_a_p1))    sync_error <= 1'b1;
    else if (err_clear)                         sync_error <= 1'b0;
  end

`ifdef VGA_CAP_LINE_CRC_EN
  logic [31:0] line_acc;

  // Per-line CRC restarted every line; published the cycle after line_end.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      line_acc  <= CRC_INIT;
      line_done <= 1'b0;
      line_crc  <= '0;
      line_num  <= '0;
    end else begin
      line_done <= 1'b0;
      if (state == SEARCH || rearm) begin
        line_acc <= CRC_INIT;
      end else if (pixel) begin
        line_acc <= crc24_step(line_acc, rgb_p1);
      end else if (line_end) begin
        line_done <= 1'b1;
        line_crc  <= line_acc ^ CRC_INIT;
        line_num  <= y;
        line_acc  <= CRC_INIT;
      end
    end
  end
`endif

endmodule

// File: doc/vga_frame_capture.md
Name: vga_frame_capture

Overview:
Receiver/monitor for the VGA output stream (hs, vs, blank_n, r/g/b) produced by the VGA controller. It recovers frame and line boundaries, measures the active width and height, and computes a per-frame CRC-32 over active pixels. It reports frame completion, dimension errors and sync errors. It sits on the vga_clk domain beside the VGA pins, for on-board self-check and for closed-loop simulation of the framebuffer path.

Parameters:
EXP_WIDTH, 640, expected active pixels per line
EXP_HEIGHT, 480, expected active lines per frame
HS_ACTIVE_LOW, 1, 1 = hs asserted when low
VS_ACTIVE_LOW, 1, 1 = vs asserted when low
CNT_W, 12, width of x/y counters and dimension outputs

Ports:
vga_clk  in  1  pixel clock; all logic on its rising edge
reset  in  1  asynchronous, active-high
capture_en  in  1  enable; low forces SEARCH state
err_clear  in  1  one-cycle pulse, clears sticky sync_error
vga_hs  in  1  horizontal sync
vga_vs  in  1  vertical sync
vga_blank_n  in  1  high = active pixel
vga_r  in  8  red
vga_g  in  8  green
vga_b  in  8  blue
frame_done  out  1  one-cycle pulse at frame end
frame_crc  out  32  CRC of last completed frame
active_width  out  CNT_W  width of first active line of last frame
active_height  out  CNT_W  active line count of last frame
frame_count  out  16  completed frames, wraps 0xFFFF->0
dim_error  out  1  last frame dims wrong/inconsistent; updated at frame_done
sync_error  out  1  sticky: blank_n high while hs or vs asserted
locked  out  1  high in FRAME state

Behaviour:
- Reset (async): all outputs 0, state SEARCH, CRC accumulator 0xFFFFFFFF, counters 0.
- Input stage: all video inputs registered once (s1), then again (s2). Polarity is normalised via the parameters to hs_a/vs_a (1 = asserted).
- vs_start = vs_a(s1) & ~vs_a(s2). line_end = ~blank(s1) & blank(s2). Pixel processing uses the s1 data.
- SEARCH: counters held at 0. On vs_start with capture_en=1 -> FRAME. Clear x, y, width_ref, line_mismatch and overflow; CRC accumulator = 0xFFFFFFFF.
- FRAME, pixel (blank_n s1 = 1):
  - x++ (saturates at all-ones and sets overflow).
  - CRC updated with the 24-bit word {r,g,b}, r[7] first.
  - CRC-32 poly 0x04C11DB7, non-reflected, one word per cycle.
- FRAME, line_end:
  - y++ (saturating, sets overflow).
  - If y==0, width_ref <= x; else if x != width_ref, line_mismatch <= 1.
  - x <= 0.
- FRAME, vs_start (frame end), registered outputs update one cycle after the vs_start detect:
  - frame_done = 1 for one cycle.
  - frame_crc = acc ^ 0xFFFFFFFF.
  - active_width = width_ref; active_height = y; frame_count++.
  - dim_error = (width_ref != EXP_WIDTH) | (y != EXP_HEIGHT) | line_mismatch | overflow.
  - Then re-arm as on SEARCH->FRAME entry; the state stays FRAME.
- Frame with zero active pixels: frame_crc = 0x00000000, width 0, height 0, dim_error 1 (unless EXP=0).
- A pixel and line_end cannot coincide (line_end implies blank low in s1). vs_start coincident with a pixel: the pixel is counted into the ending frame, and sync_error is set.
- A line still active at vs_start (no line_end) is not counted in height. Its pixels are still in the CRC.
- sync_error set when blank_n(s1)=1 and (hs_a|vs_a)(s1)=1. Cleared by err_clear; a set on the same cycle wins.
- capture_en low: next cycle state = SEARCH, locked=0. No frame_done; last-frame outputs hold.
- Reset mid-frame discards the partial frame; the block relocks on the next vs_start.
- Total input-to-output latency: vs edge on pins -> frame_done asserted 3 vga_clk edges later.

Optional Feature:
Macro VGA_CAP_LINE_CRC_EN.
- Defined: adds outputs line_done (1-cycle pulse, 1 cycle after line_end), line_crc[31:0], line_num[CNT_W-1:0]. line_crc is a separate CRC-32 (same poly/init/final XOR) restarted every line; line_num is the y value before increment.
- Not defined: ports absent, no line CRC logic.

Test Plan:
- Reset, then negative-sync 640x480 timing (800x525 total), pixel = {r=x[7:0], g=y[7:0], b=0x5A} -> second and later frame_done: width 640, height 480, dim_error 0, frame_crc equals bench CRC-32 model, frame_count increments by 1 per frame.
- EXP_WIDTH=8, EXP_HEIGHT=4, line 2 has 7 pixels -> active_width 8, active_height 4, dim_error 1.
- Frame with blank_n held low throughout -> frame_crc 0x00000000, height 0, dim_error 1.
- blank_n high for one cycle during hs pulse -> sync_error 1 and stays 1. err_clear pulse -> 0 next cycle.
- capture_en dropped mid-frame, then raised -> locked 0, no frame_done for the aborted frame. First frame_done comes one full frame after the next vs_start.
- Async reset asserted mid-line -> all outputs 0 immediately, locked 0. After release, relocks on the next vs edge.
